// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state type, default bit timing
// and a counter-width helper used by uart_rx_8n1 and uart_tx_8n1.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } uart_state_t;

   localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 16;

   // Counter width that never collapses to zero bits for tiny divisors.
   function automatic int unsigned clog2_safe(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_sync.sv
// N-flop synchronizer for an asynchronous single-bit input; the reset value is
// a parameter so a serial line can come out of reset reading idle.
module uart_sync #(
   parameter int unsigned STAGES    = 2,
   parameter logic        RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff <= {STAGES{RESET_VAL}};
      end else begin
         ff <= {ff[STAGES-2:0], d};
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver with mid-bit sampling, framing-error and line-break handling.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each sample point.
module uart_rx_8n1
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rxbyte,
   output logic       rxdone,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned CW = clog2_safe(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_sync_chk
      $error("uart_rx_8n1: SYNC_STAGES must be 2..3");
   end

   logic          rxs;
   logic          sample;
   uart_state_t   state;
   logic [CW-1:0] clk_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;

   uart_sync #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rxs)
   );

`ifdef UART_RX_MAJORITY_EN
   if (CLKS_PER_BIT < 8) begin : g_cpb_chk
      $error("uart_rx_8n1: CLKS_PER_BIT must be >= 8 with majority sampling");
   end

   // The whole sampling grid runs one clock late, so at each decision point
   // hist holds the nominal-1 and nominal samples and rxs is nominal+1.
   localparam logic [CW-1:0] START_PT = CW'(CLKS_PER_BIT / 2);

   logic [1:0] hist;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist <= '1;
      end else begin
         hist <= {hist[0], rxs};
      end
   end

   assign sample = (hist[1] & hist[0]) | (hist[1] & rxs) | (hist[0] & rxs);
`else
   localparam logic [CW-1:0] START_PT = CW'(CLKS_PER_BIT / 2 - 1);

   assign sample = rxs;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         clk_cnt   <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         rxbyte    <= '0;
         rxdone    <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         rxdone    <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               clk_cnt <= '0;
               if (!rxs) begin
                  state <= START;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (clk_cnt == START_PT) begin
                  clk_cnt <= '0;
                  if (!sample) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            DATA: begin
               if (clk_cnt == LAST) begin
                  clk_cnt         <= '0;
                  shift[bit_cnt]  <= sample;
                  bit_cnt         <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     state <= STOP;
                  end
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            STOP: begin
               if (clk_cnt == LAST) begin
                  clk_cnt <= '0;
                  if (sample) begin
                     rxbyte <= shift;
                     rxdone <= 1'b1;
                     state  <= IDLE;
                     busy   <= 1'b0;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= BREAK;
                  end
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            // A held-low line stays here so it cannot be re-read as new frames.
            BREAK: begin
               clk_cnt <= '0;
               if (rxs) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Self-checking bench for uart_rx_8n1: directed scenarios plus random frames,
// compared against an event-level model of the expected strobes and bytes.
module tb_uart_rx_8n1;

   localparam int unsigned CPB = 16;
   localparam int unsigned MID = CPB / 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic [7:0] rxbyte;
   logic       rxdone;
   logic       frame_err;
   logic       busy;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [8:0] got_q[$];
   logic [8:0] exp_q[$];
   int         done_cyc[$];
   logic [7:0] last_good;
   logic       busy_seen;

   uart_rx_8n1 #(
      .CLKS_PER_BIT (CPB),
      .SYNC_STAGES  (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .rxbyte    (rxbyte),
      .rxdone    (rxdone),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Observed events: bit 8 marks a framing error, low bits carry rxbyte.
   always @(negedge clk) begin
      if (rst_n) begin
         if (busy) busy_seen = 1'b1;
         if (rxdone || frame_err) begin
            check("strobe_excl", {31'b0, rxdone & frame_err}, 32'd0);
            if (rxdone) begin
               check("busy_at_done", {31'b0, busy}, 32'd0);
               got_q.push_back({1'b0, rxbyte});
               done_cyc.push_back(cyc);
            end else begin
               got_q.push_back({1'b1, rxbyte});
            end
         end
      end
   end

   task automatic expect_good(input logic [7:0] b);
      exp_q.push_back({1'b0, b});
      last_good = b;
   endtask

   task automatic expect_bad();
      exp_q.push_back({1'b1, last_good});
   endtask

   task automatic drive(input logic v, input int unsigned n);
      rx = v;
      repeat (n) @(negedge clk);
   endtask

   // spike: invert the line for the one clock MID clocks into each data bit.
   task automatic send_frame(input logic [7:0] b, input logic stop_val,
                             input int unsigned stop_len, input logic spike);
      drive(1'b0, CPB);
      for (int i = 0; i < 8; i++) begin
         if (spike) begin
            drive(b[i], MID);
            drive(~b[i], 1);
            drive(b[i], CPB - MID - 1);
         end else begin
            drive(b[i], CPB);
         end
      end
      drive(stop_val, stop_len);
   endtask

   task automatic compare_events(input string tag);
      check($sformatf("%s_count", tag), got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         check($sformatf("%s_ev%0d", tag, i), {23'b0, got_q[i]}, {23'b0, exp_q[i]});
      end
      got_q.delete();
      exp_q.delete();
      done_cyc.delete();
   endtask

   initial begin
      logic [7:0] b;
      logic       bad;
      int unsigned gap;
      logic [7:0] spike_exp;

      rst_n     = 1'b0;
      rx        = 1'b1;
      last_good = 8'h00;
      busy_seen = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_rxbyte", {24'b0, rxbyte}, 32'h00);
      check("rst_rxdone", {31'b0, rxdone}, 32'd0);
      check("rst_ferr", {31'b0, frame_err}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      rst_n = 1'b1;
      drive(1'b1, 2 * CPB);

      // single clean frame
      send_frame(8'h55, 1'b1, CPB, 1'b0);
      expect_good(8'h55);
      drive(1'b1, 2 * CPB);
      check("x55_busy_after", {31'b0, busy}, 32'd0);
      compare_events("x55");

      // back-to-back frames with no idle between them
      send_frame(8'h00, 1'b1, CPB, 1'b0);
      send_frame(8'hFF, 1'b1, CPB, 1'b0);
      expect_good(8'h00);
      expect_good(8'hFF);
      drive(1'b1, 2 * CPB);
      check("b2b_pulses", done_cyc.size(), 32'd2);
      if (done_cyc.size() == 2)
         check("b2b_spacing", done_cyc[1] - done_cyc[0], 10 * CPB);
      compare_events("b2b");

      // short low glitch rejected as a false start
      busy_seen = 1'b0;
      drive(1'b0, 4);
      drive(1'b1, 2 * CPB);
      check("glitch_busy_seen", {31'b0, busy_seen}, 32'd1);
      check("glitch_busy_end", {31'b0, busy}, 32'd0);
      compare_events("glitch");

      // stop bit held low as a line break, then a clean frame
      send_frame(8'hA5, 1'b0, 40 * CPB, 1'b0);
      expect_bad();
      check("break_busy_held", {31'b0, busy}, 32'd1);
      drive(1'b1, 2 * CPB);
      send_frame(8'h3C, 1'b1, CPB, 1'b0);
      expect_good(8'h3C);
      drive(1'b1, 2 * CPB);
      compare_events("break");

      // reset in the middle of a frame
      drive(1'b0, CPB);
      for (int i = 0; i < 4; i++) drive(i == 0, CPB);
      drive(1'b0, MID);
      rst_n = 1'b0;
      rx    = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_rxbyte", {24'b0, rxbyte}, 32'h00);
      check("midrst_busy", {31'b0, busy}, 32'd0);
      last_good = 8'h00;
      rst_n = 1'b1;
      drive(1'b1, 2 * CPB);
      send_frame(8'h7E, 1'b1, CPB, 1'b0);
      expect_good(8'h7E);
      drive(1'b1, 2 * CPB);
      compare_events("midrst");

      // one-clock inverted spike at the middle of every data bit
`ifdef UART_RX_MAJORITY_EN
      spike_exp = 8'hC3;
`else
      spike_exp = 8'h3C;
`endif
      send_frame(8'hC3, 1'b1, CPB, 1'b1);
      expect_good(spike_exp);
      drive(1'b1, 2 * CPB);
      compare_events("spike");

      // random frames with random gaps and occasional bad stop bits
      for (int n = 0; n < 24; n++) begin
         b   = 8'($urandom);
         bad = ($urandom_range(0, 7) == 0);
         gap = $urandom_range(0, 2 * CPB);
         if (bad) begin
            gap = gap + CPB;
            expect_bad();
         end else begin
            expect_good(b);
         end
         send_frame(b, ~bad, CPB, 1'b0);
         drive(1'b1, gap);
      end
      drive(1'b1, 2 * CPB);
      check("rand_idle_busy", {31'b0, busy}, 32'd0);
      compare_events("rand");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
